// File: rtl/ft_arb_pkg.sv
// ft_arb_pkg: shared types and constants for the OUT FIFO frame arbiter.
`default_nettype none

package ft_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_CH   = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5
  } arb_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // CH byte layout: upper bits reserved as zero, channel index in the low bits
  typedef struct packed {
    logic [4:0] rsvd;
    logic [2:0] id;
  } ch_byte_t;

  function automatic logic [7:0] ch_byte(input logic [2:0] id);
    ch_byte_t b;
    b.rsvd = 5'd0;
    b.id   = id;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ft_out_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_grant+1 with wrap.
`default_nettype none

module rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [2:0]        last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [2:0]        grant_id
);

  logic found;
  int   target;

  always_comb begin
    grant    = '0;
    grant_id = 3'd0;
    found    = 1'b0;
    target   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      target = int'(last_grant) + i;
      if (target >= NUM_CH) target = target - NUM_CH;
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found && req[j] && (j == target)) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          grant_id = 3'(j);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ft_out_arbiter.sv
// ft_out_arbiter: packet-granular round-robin sharing of the OUT FIFO write port.
// Frame = SYNC, CH, LEN, payload; define FT_ARB_CHECKSUM_EN to append an XOR checksum byte.
`default_nettype none

module ft_out_arbiter
  import ft_arb_pkg::*;
#(
  parameter int         NUM_CH    = 2,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [NUM_CH-1:0]     ch_req_i,
  input  logic [NUM_CH*8-1:0]   ch_len_i,
  input  logic [NUM_CH*8-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]     ch_rd_o,
  output logic [NUM_CH-1:0]     ch_grant_o,
  output logic                  wr_out_fifo_en_o,
  output logic [7:0]            wr_out_fifo_data_o,
  input  logic                  wr_out_fifo_full_i,
  input  logic                  wr_out_fifo_afull_i
);

  arb_state_t        state, state_nxt;
  logic [NUM_CH-1:0] grant_q;
  logic [2:0]        grant_id_q;
  logic [2:0]        last_grant_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
`ifdef FT_ARB_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              emit;
  logic              take;
  logic              en_nxt;
  logic [7:0]        data_nxt;
  logic [NUM_CH-1:0] rr_grant;
  logic [2:0]        rr_id;
  logic [7:0]        sel_len;
  logic [7:0]        sel_data;

  assign emit       = ~wr_out_fifo_afull_i & ~wr_out_fifo_full_i;
  assign ch_grant_o = grant_q;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req        (ch_req_i),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .grant_id   (rr_id)
  );

  // One-hot muxes: length from the new winner, payload from the frame owner
  always_comb begin
    sel_len  = 8'd0;
    sel_data = 8'd0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (rr_grant[j]) sel_len  = sel_len  | ch_len_i[j*8 +: 8];
      if (grant_q[j])  sel_data = sel_data | ch_data_i[j*8 +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    en_nxt    = 1'b0;
    data_nxt  = wr_out_fifo_data_o;
    take      = 1'b0;
    ch_rd_o   = '0;
    case (state)
      ST_IDLE: begin
        if (|ch_req_i) begin
          take      = 1'b1;
          state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (emit) begin
          en_nxt    = 1'b1;
          data_nxt  = SYNC_BYTE;
          state_nxt = ST_CH;
        end
      end
      ST_CH: begin
        if (emit) begin
          en_nxt    = 1'b1;
          data_nxt  = ch_byte(grant_id_q);
          state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        if (emit) begin
          en_nxt    = 1'b1;
          data_nxt  = len_q;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (emit) begin
          en_nxt   = 1'b1;
          data_nxt = sel_data;
          ch_rd_o  = grant_q;
          if (cnt_q == len_q) begin
`ifdef FT_ARB_CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_IDLE;
`endif
          end
        end
      end
`ifdef FT_ARB_CHECKSUM_EN
      ST_CSUM: begin
        if (emit) begin
          en_nxt    = 1'b1;
          data_nxt  = csum_q;
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state              <= ST_IDLE;
      wr_out_fifo_en_o   <= 1'b0;
      wr_out_fifo_data_o <= 8'd0;
    end else begin
      state              <= state_nxt;
      wr_out_fifo_en_o   <= en_nxt;
      wr_out_fifo_data_o <= data_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grant_q      <= '0;
      grant_id_q   <= 3'd0;
      last_grant_q <= 3'(NUM_CH - 1);
      len_q        <= 8'd0;
      cnt_q        <= 8'd0;
    end else begin
      if (take) begin
        grant_q      <= rr_grant;
        grant_id_q   <= rr_id;
        last_grant_q <= rr_id;
        len_q        <= sel_len;
      end else if (state != ST_IDLE && state_nxt == ST_IDLE) begin
        grant_q <= '0;
      end
      if (emit && state == ST_LEN)  cnt_q <= 8'd0;
      if (emit && state == ST_DATA) cnt_q <= cnt_q + 8'd1;
    end
  end

`ifdef FT_ARB_CHECKSUM_EN
  // Running XOR over CH, LEN and payload, seeded by the CH byte
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      csum_q <= 8'd0;
    end else if (emit) begin
      case (state)
        ST_CH:   csum_q <= ch_byte(grant_id_q);
        ST_LEN:  csum_q <= csum_q ^ len_q;
        ST_DATA: csum_q <= csum_q ^ sel_data;
        default: csum_q <= csum_q;
      endcase
    end
  end
`endif

endmodule

`default_nettype wire
